// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch-stage types, constants and opcodes
package instruction_fetch_pkg;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

  // Opcodes shared with the control unit and the decode hazard logic
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_hold_buffer.sv
// rtl/if_hold_buffer.sv - one-entry {instr, pc4} holding register for stalled fetches
module if_hold_buffer
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drop,
  input  ifid_entry_t din,
  output logic        valid,
  output ifid_entry_t dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (drop) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS IF stage: PC, imem req/ack, IF/ID regs; IF_PERF_CNT_EN adds counters
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        BorJ,
  input  logic [31:0] target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_if,
  output logic [31:0] PC_add_four_if,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic        acked;
  logic [31:0] pc4;
  logic [31:0] redirect_pc;
  logic        buf_load, buf_drop, buf_valid;
  logic        load_valid, load_bubble;
  ifid_entry_t buf_dout;

  assign acked       = imem_req & imem_ack;
  assign pc4         = pc_plus4(pc);
  assign redirect_pc = target_pc & ~32'h3;

  always_comb begin
    buf_load    = 1'b0;
    buf_drop    = BorJ;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    if (BorJ) begin
      load_bubble = 1'b1;
    end else begin
      case (state)
        ST_FETCH: begin
          if (acked && !stall_in)  load_valid  = 1'b1;
          else if (acked)          buf_load    = 1'b1;
          else if (!stall_in)      load_bubble = 1'b1;
        end
        ST_HOLD: begin
          if (!stall_in) begin
            load_valid = 1'b1;
            buf_drop   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  if_hold_buffer u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .drop  (buf_drop),
    .din   ('{instr: imem_rdata, pc4: pc4}),
    .valid (buf_valid),
    .dout  (buf_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= 32'h0;
    end else if (BorJ) begin
      pc <= redirect_pc;
      // An unacknowledged request must complete before the new target is issued
      if (imem_req && !imem_ack) begin
        state <= ST_DRAIN;
      end else begin
        state     <= ST_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= redirect_pc;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (acked) begin
            pc <= pc4;
            if (stall_in) begin
              state    <= ST_HOLD;
              imem_req <= 1'b0;
            end else begin
              imem_addr <= pc4;
            end
          end else if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_HOLD: begin
          if (!stall_in) begin
            state     <= ST_FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            state     <= ST_FETCH;
            imem_addr <= pc;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_if <= NOP_INSTR;
      PC_add_four_if <= 32'h0;
      if_valid       <= 1'b0;
    end else if (load_bubble) begin
      instruction_if <= NOP_INSTR;
      PC_add_four_if <= 32'h0;
      if_valid       <= 1'b0;
    end else if (load_valid) begin
      if (state == ST_HOLD) begin
        instruction_if <= buf_dout.instr;
        PC_add_four_if <= buf_dout.pc4;
        if_valid       <= buf_valid;
      end else begin
        instruction_if <= imem_rdata;
        PC_add_four_if <= pc4;
        if_valid       <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (load_valid)  fetch_cnt  <= fetch_cnt + 32'd1;
      if (load_bubble) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, BorJ, imem_ack;
  logic [31:0] target_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, instruction_if, PC_add_four_if;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .BorJ           (BorJ),
    .target_pc      (target_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instruction_if (instruction_if),
    .PC_add_four_if (PC_add_four_if),
    .if_valid       (if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: PC, one outstanding request, parked word, stale flag
  logic        m_req;
  logic [31:0] m_addr, m_pc, m_instr, m_pc4;
  logic        m_valid, m_stale;
  logic [63:0] m_parked[$];
  logic [31:0] m_fcnt, m_bcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_addr = 0; m_pc = 0; m_instr = 0; m_pc4 = 0;
    m_valid = 0; m_stale = 0; m_fcnt = 0; m_bcnt = 0;
    m_parked.delete();
  endtask

  task automatic model_bubble();
    m_instr = 0; m_pc4 = 0; m_valid = 0; m_bcnt++;
  endtask

  task automatic model_step(input bit ack, input bit stall, input bit borj, input logic [31:0] tgt);
    logic [63:0] e;
    if (borj) begin
      m_parked.delete();
      model_bubble();
      m_pc = {tgt[31:2], 2'b00};
      if (m_req && !ack) m_stale = 1;
      else begin m_stale = 0; m_req = 1; m_addr = m_pc; end
    end else if (m_stale) begin
      if (ack) begin m_stale = 0; m_addr = m_pc; end
    end else if (m_parked.size() != 0) begin
      if (!stall) begin
        e = m_parked.pop_front();
        m_instr = e[63:32]; m_pc4 = e[31:0]; m_valid = 1; m_fcnt++;
        m_req = 1; m_addr = m_pc;
      end
    end else if (m_req && ack) begin
      m_pc = m_addr + 32'd4;
      if (stall) begin
        m_parked.push_back({m_addr + 32'h100, m_pc});
        m_req = 0;
      end else begin
        m_instr = m_addr + 32'h100; m_pc4 = m_pc; m_valid = 1; m_fcnt++;
        m_addr = m_pc;
      end
    end else begin
      if (!m_req) begin m_req = 1; m_addr = m_pc; end
      if (!stall) model_bubble();
    end
  endtask

  task automatic check_all();
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    check("imem_addr", imem_addr, m_addr);
    check("instruction_if", instruction_if, m_instr);
    check("PC_add_four_if", PC_add_four_if, m_pc4);
    check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fcnt);
    check("bubble_cnt", bubble_cnt, m_bcnt);
`endif
  endtask

  task automatic cyc(input bit ack, input bit stall, input bit borj, input logic [31:0] tgt);
    imem_ack = ack; stall_in = stall; BorJ = borj; target_pc = tgt;
    imem_rdata = m_addr + 32'h100;
    model_step(ack, stall, borj, tgt);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 0; imem_ack = 0; stall_in = 0; BorJ = 0; target_pc = 0; imem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instruction_if, 32'h0);
    check("rst_pc4", PC_add_four_if, 32'h0);
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    rst = 1;
  endtask

`ifdef IF_PERF_CNT_EN
  logic [31:0] bub_before;
`endif

  initial begin
    apply_reset();

    // Back-to-back acks
    cyc(1, 0, 0, 0);
    check("t1_addr0", imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    check("t1_instr0", instruction_if, 32'h100);
    check("t1_pc4_0", PC_add_four_if, 32'h4);
    cyc(1, 0, 0, 0);
    check("t1_instr1", instruction_if, 32'h104);
    check("t1_pc4_1", PC_add_four_if, 32'h8);
    check("t1_addr2", imem_addr, 32'h8);

    // Two-cycle ack latency
    apply_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("t2_hold_addr", imem_addr, 32'h0);
    check("t2_bubble", {31'b0, if_valid}, 32'h0);
    cyc(1, 0, 0, 0);
    check("t2_instr", instruction_if, 32'h100);
    check("t2_next_addr", imem_addr, 32'h4);

    // Stall asserted with the ack for addr 8
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("t3_hold_instr", instruction_if, 32'h104);
    check("t3_hold_req", {31'b0, imem_req}, 32'h0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("t3_still_instr", instruction_if, 32'h104);
    cyc(0, 0, 0, 0);
    check("t3_release_instr", instruction_if, 32'h108);
    check("t3_resume_addr", imem_addr, 32'hC);

    // Redirect while the request to 12 is pending
`ifdef IF_PERF_CNT_EN
    bub_before = bubble_cnt;
`endif
    cyc(0, 0, 1, 32'h40);
    check("t4_bubble", {31'b0, if_valid}, 32'h0);
    check("t4_drain_addr", imem_addr, 32'hC);
    cyc(1, 0, 0, 0);
    check("t4_new_addr", imem_addr, 32'h40);
    check("t4_still_bubble", {31'b0, if_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("t4_one_bubble", bubble_cnt - bub_before, 32'h1);
`endif
    cyc(1, 0, 0, 0);
    check("t4_instr", instruction_if, 32'h140);

    // Redirect with stall and ack together, then redirect dropping a parked word
    cyc(1, 1, 1, 32'h80);
    check("t5_addr", imem_addr, 32'h80);
    check("t5_bubble", {31'b0, if_valid}, 32'h0);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 32'h200);
    check("t5_drop_addr", imem_addr, 32'h200);
    cyc(1, 0, 0, 0);
    check("t5_instr", instruction_if, 32'h300);

    // PC wrap at the top of the address space, low target bits ignored
    cyc(1, 0, 1, 32'hFFFF_FFFF);
    check("t6_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    check("t6_pc4", PC_add_four_if, 32'h0);
    check("t6_instr", instruction_if, 32'h0000_00FC);
    check("t6_next_addr", imem_addr, 32'h0);

    // Asynchronous reset in the middle of a request
    cyc(0, 0, 0, 0);
    rst = 0;
    #1;
    check("async_rst_req", {31'b0, imem_req}, 32'h0);
    apply_reset();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
          $urandom_range(0, 11) == 0, tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. Owns the PC and issues requests to instruction memory over a req/ack handshake. Registers the fetched word and PC+4 into the IF/ID outputs (instruction_if, PC_add_four_if). Honours the decode load-use stall and branch/jump redirects, inserting NOP bubbles where required.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by reset
NOP_INSTR, 32'h0000_0000, word driven on instruction_if for a bubble

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-low
stall_in  in  1  decode stall_out; hold IF/ID outputs
BorJ  in  1  taken branch/jump redirect
target_pc  in  32  redirect address, sampled when BorJ=1
imem_req  out  1  instruction memory request
imem_addr  out  32  word address of the request
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction
instruction_if  out  32  IF/ID instruction
PC_add_four_if  out  32  IF/ID PC+4
if_valid  out  1  instruction_if holds a real instruction (not a bubble)

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=FETCH, buffer empty.
  - instruction_if=NOP_INSTR, PC_add_four_if=0, if_valid=0, imem_req=0, imem_addr=0.
- Handshake:
  - imem_req and imem_addr are registered.
  - Once a request is raised, imem_req and imem_addr stay stable until the cycle imem_ack=1.
  - imem_ack may arrive in the first request cycle or any later one.
  - A new request may be raised in the cycle after an ack.
- States:
  - FETCH: req=1, addr=pc.
    - ack & !stall_in & !BorJ: outputs <= {rdata, pc+4}, if_valid<=1, pc<=pc+4; stay in FETCH.
    - ack & stall_in: capture {rdata, pc+4} into the hold buffer, pc<=pc+4 → HOLD. Outputs unchanged.
    - !ack & !stall_in: outputs <= bubble (NOP_INSTR, 0, if_valid=0).
    - !ack & stall_in: outputs unchanged.
  - HOLD: req=0. When !stall_in: outputs <= buffer, if_valid<=1 → FETCH.
  - DRAIN: req=1 at the old address. On ack, discard rdata → FETCH at pc. Outputs stay bubble.
- Stall: while stall_in=1, the IF/ID outputs never change (except on BorJ). Latency from ack to instruction_if is 1 cycle when unstalled.
- Redirect: BorJ has priority over stall_in and ack.
  - pc<=target_pc, buffer dropped, outputs <= bubble.
  - From FETCH without ack in the same cycle → DRAIN. Otherwise → FETCH, and the next request uses target_pc.
  - BorJ in DRAIN: pc updated again, remain in DRAIN.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. target_pc[1:0] are ignored (forced to 00).
- Reset mid-request: the request is abandoned, imem_req drops asynchronously, and the memory must tolerate the abandoned transaction.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_cnt[31:0] and bubble_cnt[31:0], both reset to 0 and wrapping.
  - fetch_cnt increments on each cycle in which a valid instruction is loaded into the IF/ID outputs.
  - bubble_cnt increments on each cycle the outputs are loaded with a bubble (ack missing or BorJ).
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - fetch state enum {FETCH, HOLD, DRAIN}.
  - NOP constant.
  - RESET_PC default.
  - Opcode constants already used by the control unit, so the decode stall logic can share them.
- One natural sub-module: if_hold_buffer, a one-entry {instr, pc4} register with load, drop and valid.
- PC/FSM logic and IF/ID output registers live in the top.

Test Plan:
- Reset release, ack every cycle with rdata = addr+32'h100:
  - imem_addr sequence 0,4,8.
  - instruction_if = 32'h100, 32'h104 from the second cycle after the first ack.
  - PC_add_four_if = 4, 8.
- Ack with 2-cycle latency:
  - imem_req/imem_addr hold 0 for 3 cycles.
  - Bubble outputs (if_valid=0) until instruction arrives.
  - Next imem_addr = 4.
- stall_in=1 for 3 cycles, asserted in the cycle of the ack for addr 8:
  - Outputs hold the addr-4 word.
  - State=HOLD, imem_req=0.
  - After stall release, instruction_if = word@8, then fetch resumes at 12.
- BorJ with target_pc=32'h40 while a request to 12 is pending (no ack):
  - Outputs become bubble; DRAIN discards word@12.
  - Next request addr = 32'h40.
  - Exactly one bubble counted with IF_PERF_CNT_EN defined.
- BorJ and stall_in together, with ack: redirect wins, buffer dropped, next addr = target_pc.
- pc=32'hFFFF_FFFC, acked: PC_add_four_if = 0, next imem_addr = 0.
